lfsr_period_checker: RTL

//   Downstream consumer of the 9-bit LFSR stage. On a start pulse it captures the current

---
 rtl/lfsr_period_checker_if.sv | 25 ++
 rtl/lfsr_period_checker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lfsr_period_checker_if.sv
// Stimulus and result signals exchanged between an LFSR sample source and the
// period checker; the source side is the master, the checker side is the slave.
interface lfsr_period_checker_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 10
);
  logic             start;
  logic             sample_en;
  logic [WIDTH-1:0] lfsr_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic             timeout;
  logic             zero_err;

  modport master (
    output start, sample_en, lfsr_in,
    input  busy, done, period, timeout, zero_err
  );

  modport slave (
    input  start, sample_en, lfsr_in,
    output busy, done, period, timeout, zero_err
  );
endinterface

// File: rtl/lfsr_period_checker.sv
// Measures the repeat period of an LFSR word stream: captures a reference word,
// counts valid samples until it recurs, and flags lock-up (all-zero) or runaway.
module lfsr_period_checker #(
  parameter int WIDTH   = 9,
  parameter int CNT_W   = 10,
  parameter int MAX_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 rst_b,
  lfsr_period_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q, done_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             timeout_q, timeout_d;
  logic             zero_err_q, zero_err_d;
  logic             word_zero;
  logic             word_match;

  always_comb begin
    // NOTE: every value driven here is given its default first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    ref_d      = ref_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    period_d   = period_q;
    timeout_d  = timeout_q;
    zero_err_d = zero_err_q;
    cnt_inc    = cnt_q + 1'b1;
    word_zero  = (bus.lfsr_in == '0);
    word_match = (bus.lfsr_in == ref_q);

    if (bus.start) begin
      // Start from any state (including a restart mid-measurement) wins over sampling.
      state_d    = ST_ARM;
      cnt_d      = '0;
      done_d     = 1'b0;
      period_d   = '0;
      timeout_d  = 1'b0;
      zero_err_d = 1'b0;
    end else if (bus.sample_en) begin
      unique case (state_q)
        ST_ARM: begin
          ref_d = bus.lfsr_in;
          cnt_d = '0;
          if (word_zero) begin
            zero_err_d = 1'b1;
            done_d     = 1'b1;
            period_d   = '0;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (word_match) begin
            period_d = cnt_inc;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (word_zero) begin
            zero_err_d = 1'b1;
            period_d   = cnt_inc;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else if (cnt_inc == MAX_CNT) begin
            // Abort before cnt could approach its wrap point.
            timeout_d = 1'b1;
            period_d  = MAX_CNT;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          // IDLE and DONE ignore samples; results stay frozen until the next start.
        end
      endcase
    end
  end

  // NOTE: every register, including the reference word and counter, is cleared by reset so a reset mid-measurement leaves no stale state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      ref_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      period_q   <= '0;
      timeout_q  <= 1'b0;
      zero_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q    <= state_d;
      ref_q      <= ref_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      period_q   <= period_d;
      timeout_q  <= timeout_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign bus.busy     = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign bus.done     = done_q;
  assign bus.period   = period_q;
  assign bus.timeout  = timeout_q;
  assign bus.zero_err = zero_err_q;

endmodule
